// File: rtl/common_pkg.sv
// Shared definitions for the ALU arbiter slice: data width, ALU operation
// encoding and the arbiter state encoding. ALU_ARB_RR_EN (defined in the
// arbiter build) selects round-robin arbitration; it does not affect this file.
package common_pkg;

   localparam int RISC_V_DATA_WIDTH = 32;

   // Classic RISC-V ALU control encoding; any other value is treated as illegal.
   typedef enum logic [3:0] {
      ALU_AND = 4'b0000,
      ALU_OR  = 4'b0001,
      ALU_ADD = 4'b0010,
      ALU_SUB = 4'b0110
   } ALU_ctrl_t;

   // Arbiter state encoding, kept as fixed constants for older tooling.
   localparam logic [1:0] ARB_IDLE_C = 2'd0;
   localparam logic [1:0] ARB_EXEC_C = 2'd1;
   localparam logic [1:0] ARB_RESP_C = 2'd2;

   typedef enum logic [1:0] {
      IDLE = ARB_IDLE_C,
      EXEC = ARB_EXEC_C,
      RESP = ARB_RESP_C
   } arb_state_t;

endpackage

// File: rtl/alu.sv
// Combinational ALU: AND/OR/ADD/SUB on two's-complement operands.
// ADD/SUB wrap modulo 2^DATA_W; illegal operation codes produce zero.
module alu
   import common_pkg::*;
#(
   parameter int DATA_W = RISC_V_DATA_WIDTH
) (
   input  logic signed [DATA_W-1:0] a,
   input  logic signed [DATA_W-1:0] b,
   input  ALU_ctrl_t                op,
   output logic signed [DATA_W-1:0] result,
   output logic                     zero
);

   // Operation select; unknown codes fall through to zero.
   always_comb begin
      result = '0;
      case (op)
         ALU_AND: result = a & b;
         ALU_OR:  result = a | b;
         ALU_ADD: result = a + b;
         ALU_SUB: result = a - b;
         default: result = '0;
      endcase
   end

   assign zero = (result == '0);

endmodule

// File: rtl/alu_arbiter.sv
// Two-requester front end to a single shared ALU.
// Flow: IDLE (grant + accept) -> EXEC (ALU runs on latched operands) ->
// RESP (result held until the owner takes it) -> IDLE.
// Build option: define ALU_ARB_RR_EN for round-robin arbitration; otherwise
// req0 has fixed priority and no last-grant state exists.
//
// Handshake: a transfer happens on a rising clk edge where valid && ready are
// both high. reqN_ready depends on reqN_valid (ready is only raised for the
// granted requester that is actually offering); rspN_valid is a registered
// state decode and is held, with data/zero stable, until rspN_ready is seen.
module alu_arbiter
   import common_pkg::*;
#(
   parameter int DATA_W = RISC_V_DATA_WIDTH
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     req0_valid,
   output logic                     req0_ready,
   input  logic signed [DATA_W-1:0] req0_a,
   input  logic signed [DATA_W-1:0] req0_b,
   input  ALU_ctrl_t                req0_op,
   output logic                     rsp0_valid,
   output logic signed [DATA_W-1:0] rsp0_data,
   output logic                     rsp0_zero,
   input  logic                     rsp0_ready,
   input  logic                     req1_valid,
   output logic                     req1_ready,
   input  logic signed [DATA_W-1:0] req1_a,
   input  logic signed [DATA_W-1:0] req1_b,
   input  ALU_ctrl_t                req1_op,
   output logic                     rsp1_valid,
   output logic signed [DATA_W-1:0] rsp1_data,
   output logic                     rsp1_zero,
   input  logic                     rsp1_ready,
   output arb_state_t               state_dbg
);

   arb_state_t               state;
   arb_state_t               state_nxt;
   logic                     grant;
   logic                     acc0;
   logic                     acc1;
   logic                     accept;
   logic                     rsp_hs;
   logic signed [DATA_W-1:0] a_q;
   logic signed [DATA_W-1:0] b_q;
   ALU_ctrl_t                op_q;
   logic                     owner_q;
   logic signed [DATA_W-1:0] alu_res;
   logic                     alu_zero;
   logic signed [DATA_W-1:0] res_q;
   logic                     zero_q;

`ifdef ALU_ARB_RR_EN
   logic                     last_grant;

   // Round-robin: on contention, favour whoever did not win last time.
   always_comb begin
      grant = 1'b0;
      if (req1_valid && (!req0_valid || !last_grant))
         grant = 1'b1;
   end

   // Remember the winner of every accept.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         last_grant <= 1'b1;
      else if (accept)
         last_grant <= acc1;
   end
`else
   // Fixed priority: req1 wins only when req0 is not offering.
   always_comb begin
      grant = 1'b0;
      if (req1_valid && !req0_valid)
         grant = 1'b1;
   end
`endif

   assign req0_ready = (state == IDLE) && !grant && req0_valid;
   assign req1_ready = (state == IDLE) &&  grant && req1_valid;
   assign acc0       = req0_valid && req0_ready;
   assign acc1       = req1_valid && req1_ready;
   assign accept     = acc0 || acc1;
   assign rsp_hs     = (state == RESP) && (owner_q ? rsp1_ready : rsp0_ready);

   // Next-state decode for the IDLE -> EXEC -> RESP loop.
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (accept) state_nxt = EXEC;
         EXEC:    state_nxt = RESP;
         RESP:    if (rsp_hs) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // State register; reset abandons any in-flight operation.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         state <= IDLE;
      else
         state <= state_nxt;
   end

   // Capture operands and owner only on the accept edge.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         a_q     <= '0;
         b_q     <= '0;
         op_q    <= ALU_ctrl_t'(4'd0);
         owner_q <= 1'b0;
      end else if (accept) begin
         a_q     <= acc1 ? req1_a  : req0_a;
         b_q     <= acc1 ? req1_b  : req0_b;
         op_q    <= acc1 ? req1_op : req0_op;
         owner_q <= acc1;
      end
   end

   alu #(.DATA_W(DATA_W)) u_alu (
      .a      (a_q),
      .b      (b_q),
      .op     (op_q),
      .result (alu_res),
      .zero   (alu_zero)
   );

   // Register the ALU output during EXEC so RESP presents a stable value.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         res_q  <= '0;
         zero_q <= 1'b0;
      end else if (state == EXEC) begin
         res_q  <= alu_res;
         zero_q <= alu_zero;
      end
   end

   assign rsp0_valid = (state == RESP) && !owner_q;
   assign rsp1_valid = (state == RESP) &&  owner_q;
   assign rsp0_data  = res_q;
   assign rsp1_data  = res_q;
   assign rsp0_zero  = zero_q;
   assign rsp1_zero  = zero_q;
   assign state_dbg  = state;

endmodule

// File: tb/tb_alu_arbiter.sv
// Bench for alu_arbiter: a transaction-level model (pending-result queue plus
// a cycle timeline) checked every cycle, and directed vectors with literal
// expected values.
`timescale 1ns/1ps
module tb_alu_arbiter;
   import common_pkg::*;

   localparam int W = RISC_V_DATA_WIDTH;
`ifdef ALU_ARB_RR_EN
   localparam bit RR = 1'b1;
`else
   localparam bit RR = 1'b0;
`endif

   // ---------------- clock / reset ----------------
   logic clk   = 1'b0;
   logic rst_n = 1'b1;
   always #5 clk = ~clk;

   logic                req0_valid = 1'b0, req1_valid = 1'b0;
   logic                req0_ready, req1_ready;
   logic signed [W-1:0] req0_a = '0, req0_b = '0, req1_a = '0, req1_b = '0;
   ALU_ctrl_t           req0_op = ALU_ADD, req1_op = ALU_ADD;
   logic                rsp0_valid, rsp1_valid, rsp0_zero, rsp1_zero;
   logic signed [W-1:0] rsp0_data, rsp1_data;
   logic                rsp0_ready = 1'b1, rsp1_ready = 1'b1;
   arb_state_t          state_dbg;

   alu_arbiter #(.DATA_W(W)) dut (
      .clk(clk), .rst_n(rst_n),
      .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_a(req0_a),
      .req0_b(req0_b), .req0_op(req0_op),
      .rsp0_valid(rsp0_valid), .rsp0_data(rsp0_data), .rsp0_zero(rsp0_zero),
      .rsp0_ready(rsp0_ready),
      .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_a(req1_a),
      .req1_b(req1_b), .req1_op(req1_op),
      .rsp1_valid(rsp1_valid), .rsp1_data(rsp1_data), .rsp1_zero(rsp1_zero),
      .rsp1_ready(rsp1_ready),
      .state_dbg(state_dbg)
   );

   int n_checks = 0;
   int n_fail   = 0;
   int cyc      = 0;

   task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic chk_b(input string name, input logic act, input logic exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0b expected %0b (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic chk_s(input string name, input arb_state_t act, input arb_state_t exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %s expected %s (cycle %0d)", name, act.name(), exp.name(), cyc);
      end
   endtask

   task automatic timeout(input string name);
      n_checks++;
      n_fail++;
      $display("FAIL %s: timed out (cycle %0d)", name, cyc);
   endtask

   // ---------------- reference model ----------------
   function automatic logic [W-1:0] alu_ref(input logic [W-1:0] a, input logic [W-1:0] b,
                                            input ALU_ctrl_t op);
      case (op)
         ALU_AND: return a & b;
         ALU_OR:  return a | b;
         ALU_ADD: return a + b;
         ALU_SUB: return a - b;
         default: return '0;
      endcase
   endfunction

   logic [W-1:0] exp_q[$];
   logic         exp_zq[$];
   logic         exp_oq[$];
   int           acc_cyc = 0;
   logic         m_last  = 1'b1;
   logic         m_busy, m_g, e_r0, e_r1, e_v, e_own;
   arb_state_t   e_st;

   // Scoreboard: one pending result at most; response due two cycles after accept.
   always @(negedge clk) begin
      if (!rst_n) begin
         exp_q.delete();
         exp_zq.delete();
         exp_oq.delete();
         m_last = 1'b1;
      end else begin
         m_busy = (exp_q.size() != 0);
         if (req0_valid && req1_valid) m_g = RR ? !m_last : 1'b0;
         else                          m_g = req1_valid;
         e_r0  = !m_busy && req0_valid && !m_g;
         e_r1  = !m_busy && req1_valid &&  m_g;
         e_own = m_busy ? exp_oq[0] : 1'b0;
         e_v   = m_busy && (cyc >= acc_cyc + 2);
         e_st  = !m_busy ? IDLE : ((cyc == acc_cyc + 1) ? EXEC : RESP);
         chk_b("req0_ready", req0_ready, e_r0);
         chk_b("req1_ready", req1_ready, e_r1);
         chk_b("rsp0_valid", rsp0_valid, e_v && !e_own);
         chk_b("rsp1_valid", rsp1_valid, e_v &&  e_own);
         chk_s("state", state_dbg, e_st);
         if (e_v) begin
            chk("rsp_data", e_own ? rsp1_data : rsp0_data, exp_q[0]);
            chk_b("rsp_zero", e_own ? rsp1_zero : rsp0_zero, exp_zq[0]);
            if (e_own ? rsp1_ready : rsp0_ready) begin
               void'(exp_q.pop_front());
               void'(exp_zq.pop_front());
               void'(exp_oq.pop_front());
            end
         end
         if (e_r0 || e_r1) begin
            exp_q.push_back(e_r1 ? alu_ref(req1_a, req1_b, req1_op) : alu_ref(req0_a, req0_b, req0_op));
            exp_zq.push_back(exp_q[exp_q.size()-1] == '0);
            exp_oq.push_back(e_r1);
            acc_cyc = cyc;
            m_last  = e_r1;
         end
      end
      cyc++;
   end

   // ---------------- driver tasks ----------------
   task automatic drive(input int n, input logic [W-1:0] a, input logic [W-1:0] b, input ALU_ctrl_t op);
      if (n == 0) begin
         req0_valid = 1'b1; req0_a = a; req0_b = b; req0_op = op;
      end else begin
         req1_valid = 1'b1; req1_a = a; req1_b = b; req1_op = op;
      end
   endtask

   // Returns at #1 after the edge that followed the accept.
   task automatic wait_accept(input int n, output int acc_at);
      acc_at = -1;
      for (int k = 0; k < 20; k++) begin
         @(negedge clk); #1;
         if (n == 0 ? req0_ready : req1_ready) begin
            acc_at = cyc;
            break;
         end
      end
      @(posedge clk); #1;
      if (n == 0) req0_valid = 1'b0; else req1_valid = 1'b0;
      if (acc_at < 0) timeout("accept");
   endtask

   task automatic wait_rsp(input string name, input int n, input int acc_at,
                           input logic [W-1:0] exp_d, input logic exp_z);
      int seen;
      seen = -1;
      for (int k = 0; k < 10; k++) begin
         @(negedge clk); #1;
         if (n == 0 ? rsp0_valid : rsp1_valid) begin
            seen = cyc;
            break;
         end
      end
      if (seen < 0) timeout(name);
      else begin
         chk({name, "_latency"}, W'(seen - acc_at), W'(2));
         chk({name, "_data"}, n == 0 ? rsp0_data : rsp1_data, exp_d);
         chk_b({name, "_zero"}, n == 0 ? rsp0_zero : rsp1_zero, exp_z);
      end
      @(posedge clk); #1;
   endtask

   task automatic run_op(input string name, input int n, input logic [W-1:0] a, input logic [W-1:0] b,
                         input ALU_ctrl_t op, input logic [W-1:0] exp_d, input logic exp_z);
      int acc_at;
      drive(n, a, b, op);
      wait_accept(n, acc_at);
      wait_rsp(name, n, acc_at, exp_d, exp_z);
   endtask

   task automatic do_reset();
      @(posedge clk); #1;
      rst_n = 1'b0;
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
   endtask

   // ---------------- directed sequence ----------------
   logic [W-1:0] grants[$];
   logic [W-1:0] exp_g[4];
   logic [W-1:0] held;
   int           acc_at;
   ALU_ctrl_t    rops[5];

   initial begin
      #2 rst_n = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      chk_b("reset_rsp0_valid", rsp0_valid, 1'b0);
      chk_b("reset_rsp1_valid", rsp1_valid, 1'b0);
      chk("reset_rsp0_data", rsp0_data, '0);
      chk_b("reset_rsp0_zero", rsp0_zero, 1'b0);
      chk_s("reset_state", state_dbg, IDLE);
      rst_n = 1'b1;

      run_op("add_5_7",   0, 32'd5,          32'd7,          ALU_ADD, 32'd12,         1'b0);
      run_op("sub_3_3",   1, 32'd3,          32'd3,          ALU_SUB, 32'd0,          1'b1);
      run_op("add_ovf",   0, 32'h7FFF_FFFF,  32'd1,          ALU_ADD, 32'h8000_0000,  1'b0);
      run_op("add_wrap",  1, 32'hFFFF_FFFF,  32'd1,          ALU_ADD, 32'd0,          1'b1);
      run_op("sub_neg",   0, 32'd2,          32'd5,          ALU_SUB, 32'hFFFF_FFFD,  1'b0);
      run_op("and",       1, 32'h0000_F0F0,  32'h0000_FF00,  ALU_AND, 32'h0000_F000,  1'b0);
      run_op("or",        0, 32'h0000_F0F0,  32'h0000_FF00,  ALU_OR,  32'h0000_FFF0,  1'b0);
      run_op("illegal",   1, 32'd5,          32'd7,          ALU_ctrl_t'(4'hF), 32'd0, 1'b1);

      // Contention from a clean reset: both requesters valid for 12 cycles.
      do_reset();
      drive(0, 32'd1, 32'd2, ALU_ADD);
      drive(1, 32'd10, 32'd4, ALU_SUB);
      for (int k = 0; k < 12; k++) begin
         @(negedge clk); #1;
         if (req0_ready) grants.push_back(W'(0));
         if (req1_ready) grants.push_back(W'(1));
      end
      @(posedge clk); #1;
      req0_valid = 1'b0;
      req1_valid = 1'b0;
      exp_g = RR ? '{W'(0), W'(1), W'(0), W'(1)} : '{W'(0), W'(0), W'(0), W'(0)};
      chk("grant_count", W'(grants.size()), W'(4));
      for (int i = 0; i < 4; i++) chk($sformatf("grant_%0d", i), grants[i], exp_g[i]);
      repeat (3) @(posedge clk);
      #1;

      // Backpressure on requester 1 while requester 0 keeps asking.
      rsp1_ready = 1'b0;
      drive(1, 32'd20, 32'd22, ALU_ADD);
      wait_accept(1, acc_at);
      @(posedge clk); #1;
      chk_b("bp_rsp1_valid_start", rsp1_valid, 1'b1);
      held = rsp1_data;
      chk("bp_data", held, 32'd42);
      drive(0, 32'd1, 32'd1, ALU_ADD);
      for (int k = 0; k < 5; k++) begin
         @(negedge clk); #1;
         chk_b("bp_rsp1_valid_hold", rsp1_valid, 1'b1);
         chk("bp_rsp1_data_hold", rsp1_data, held);
         chk_b("bp_no_accept", req0_ready, 1'b0);
      end
      @(posedge clk); #1;
      rsp1_ready = 1'b1;
      @(negedge clk); #1;
      chk_s("bp_still_resp", state_dbg, RESP);
      @(posedge clk); #1;
      chk_s("bp_idle_after_release", state_dbg, IDLE);
      wait_accept(0, acc_at);
      wait_rsp("bp_next", 0, acc_at, 32'd2, 1'b0);

      // Reset while the ALU is executing.
      drive(0, 32'd9, 32'd9, ALU_ADD);
      wait_accept(0, acc_at);
      chk_s("mid_exec_state", state_dbg, EXEC);
      rst_n = 1'b0;
      #1;
      chk_b("mid_rst_rsp0_valid", rsp0_valid, 1'b0);
      chk_b("mid_rst_rsp1_valid", rsp1_valid, 1'b0);
      chk_s("mid_rst_state", state_dbg, IDLE);
      chk("mid_rst_data", rsp0_data, '0);
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
      run_op("after_reset", 0, 32'h0F, 32'hF0, ALU_OR, 32'hFF, 1'b0);

      // Short random run checked by the model alone.
      rops = '{ALU_AND, ALU_OR, ALU_ADD, ALU_SUB, ALU_ctrl_t'(4'hB)};
      for (int k = 0; k < 20; k++) begin
         drive(int'($urandom_range(0, 1)), W'($urandom), W'($urandom), rops[$urandom_range(0, 4)]);
         wait_accept(req0_valid ? 0 : 1, acc_at);
         repeat (2) @(posedge clk);
         #1;
      end

      repeat (3) @(posedge clk);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   // Global bound on run length.
   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
      $fatal(1, "watchdog");
   end

endmodule
